// File: rtl/pixel_writeback_pkg.sv
// Shared types for the pixel write-back path: the buffered pixel record and FSM encodings.
package pixel_writeback_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic [15:0] color;
  } pixel_write_t;

  typedef enum logic [1:0] {
    WB_IDLE  = 2'd0,
    WB_WRITE = 2'd1,
    WB_ERROR = 2'd2
  } wb_state_t;

  function automatic pixel_write_t make_pixel(input logic [31:0] addr, input logic [15:0] color);
    pixel_write_t px;
    px.addr  = addr;
    px.color = color;
    return px;
  endfunction

endpackage

// File: rtl/pixel_writeback_if.sv
// Pixel input handshake plus the Avalon-MM write master bus; "master" is the write-back block side.
interface pixel_writeback_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_address;
  logic [15:0] in_color;
  logic [31:0] m1_address;
  logic [15:0] m1_writedata;
  logic        m1_write;
  logic        m1_waitrequest;

  modport master (
    input  in_valid, in_address, in_color, m1_waitrequest,
    output in_ready, m1_address, m1_writedata, m1_write
  );

  modport slave (
    output in_valid, in_address, in_color, m1_waitrequest,
    input  in_ready, m1_address, m1_writedata, m1_write
  );
endinterface

// File: rtl/pixel_writeback_sync_fifo.sv
// Synchronous FIFO with a registered head entry, occupancy count and a flush that empties it in one edge.
module sync_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_r == CW'(DEPTH));
  assign empty     = (count_r == {CW{1'b0}});
  assign count     = count_r;
  assign head      = mem_r[rd_ptr_r];
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;

  // Storage, pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r <= count_r + CW'(do_push_s) - CW'(do_pop_s);
    end
  end
endmodule

// File: rtl/pixel_writeback.sv
// Buffers shader pixels and drives the framebuffer Avalon write master, flagging a stuck bus as a sticky error.
module pixel_writeback
  import pixel_writeback_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int STALL_LIMIT = 1024
) (
  input  logic                       clock,
  input  logic                       reset,
  pixel_writeback_if.master          bus,
  output logic [$clog2(DEPTH+1)-1:0] pending,
  output logic                       idle,
  output logic                       error,
  input  logic                       clear_error
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int SW = $clog2(STALL_LIMIT+1);
  localparam logic [1:0] ST_IDLE  = WB_IDLE;
  localparam logic [1:0] ST_WRITE = WB_WRITE;
  localparam logic [1:0] ST_ERROR = WB_ERROR;

  logic [1:0]    state_r;
  logic [1:0]    state_s;
  logic [SW-1:0] stall_cnt_r;
  logic [SW-1:0] stall_cnt_s;
  logic          error_r;
  logic          idle_r;
  logic          push_s;
  logic          pop_s;
  logic          flush_s;
  logic          full_s;
  logic          empty_s;
  logic [CW-1:0] count_s;
  logic [CW-1:0] count_next_s;
  pixel_write_t  head_s;

  sync_fifo #(.WIDTH($bits(pixel_write_t)), .DEPTH(DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .flush (flush_s),
    .push  (push_s),
    .pop   (pop_s),
    .din   (make_pixel(bus.in_address, bus.in_color)),
    .head  (head_s),
    .count (count_s),
    .full  (full_s),
    .empty (empty_s)
  );

  // ERROR swallows input pixels, so it always looks ready upstream.
  assign bus.in_ready     = (state_r == ST_ERROR) ? 1'b1 : !full_s;
  assign bus.m1_write     = (state_r == ST_WRITE);
  assign bus.m1_address   = head_s.addr;
  assign bus.m1_writedata = head_s.color;
  assign push_s           = bus.in_valid && bus.in_ready && (state_r != ST_ERROR);
  assign pop_s            = (state_r == ST_WRITE) && !bus.m1_waitrequest;
  assign count_next_s     = flush_s ? {CW{1'b0}} : (count_s + CW'(push_s) - CW'(pop_s));
  assign pending          = count_s;
  assign idle             = idle_r;
  assign error            = error_r;

  // Next-state, stall counter and flush decode.
  always_comb begin
    state_s     = state_r;
    stall_cnt_s = stall_cnt_r;
    flush_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (push_s) begin
          state_s = ST_WRITE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (bus.m1_waitrequest) begin
          if (stall_cnt_r >= SW'(STALL_LIMIT - 1)) begin
            state_s     = ST_ERROR;
            stall_cnt_s = {SW{1'b0}};
            flush_s     = 1'b1;
          end else begin
            stall_cnt_s = stall_cnt_r + SW'(1);
          end
        end else begin
          stall_cnt_s = {SW{1'b0}};
          if ((count_s == CW'(1)) && !push_s) begin
            state_s = ST_IDLE;
          end else begin
            state_s = ST_WRITE;
          end
        end
      end
      ST_ERROR: begin
        if (clear_error) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_ERROR;
        end
      end
      default: begin
        state_s     = ST_IDLE;
        stall_cnt_s = {SW{1'b0}};
      end
    endcase
  end

  // State and registered status flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      stall_cnt_r <= {SW{1'b0}};
      error_r     <= 1'b0;
      idle_r      <= 1'b1;
    end else begin
      state_r     <= state_s;
      stall_cnt_r <= stall_cnt_s;
      error_r     <= (state_s == ST_ERROR);
      idle_r      <= (count_next_s == {CW{1'b0}}) && (state_s != ST_ERROR);
    end
  end
endmodule
